// File: rtl/prog_lut_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prog_lut_pkg
// Purpose  : Shared types and default branch-target table for prog_target_lut.
// Revision : 1.0 - initial release
// ============================================================================
package prog_lut_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } lut_state_e;

  localparam int DEFAULT_COUNT = 6;

  // Default table value for entry idx, masked to data_w bits (LSBs kept).
  function automatic logic [31:0] default_target(input int unsigned idx,
                                                 input int unsigned data_w);
    logic [31:0] v;
    case (idx)
      0:       v = 32'h8E;
      1:       v = 32'h6D;
      2:       v = 32'h5B;
      3:       v = 32'h05;
      4:       v = 32'h17;
      5:       v = 32'h01;
      default: v = 32'h00;
    endcase
    if (data_w < 32) begin
      v = v & ((32'h1 << data_w) - 32'h1);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_target_lut_if.sv
`default_nettype none
// ============================================================================
// Module   : prog_target_lut_if
// Purpose  : Read/write/status bundle between fetch and the target table.
//            par_err exists only when LUT_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface prog_target_lut_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_target;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              init_busy;
  logic              addr_err;
`ifdef LUT_PARITY_EN
  logic              par_err;

  modport master (
    output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_target, wr_ready, init_busy, addr_err, par_err
  );
  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_valid, rd_target, wr_ready, init_busy, addr_err, par_err
  );
`else
  modport master (
    output rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    input  rd_valid, rd_target, wr_ready, init_busy, addr_err
  );
  modport slave (
    input  rd_en, rd_addr, wr_valid, wr_addr, wr_data,
    output rd_valid, rd_target, wr_ready, init_busy, addr_err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/prog_lut_init_seq.sv
`default_nettype none
// ============================================================================
// Module   : prog_lut_init_seq
// Purpose  : INIT/RUN sequencer; loads the default table one entry per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module prog_lut_init_seq
  import prog_lut_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic [DATA_W-1:0] init_data
);

  localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);

  lut_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_idx, w_idx_nxt;
  logic [31:0]       w_def;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= INIT;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    init_busy   = 1'b0;
    init_we     = 1'b0;
    case (r_state)
      INIT: begin
        init_busy = 1'b1;
        init_we   = 1'b1;
        if (r_idx == C_LAST) begin
          w_state_nxt = RUN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      RUN: begin
        w_state_nxt = RUN;
      end
      default: begin
        w_state_nxt = INIT;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign init_addr = r_idx;
  assign w_def     = default_target(32'(r_idx), 32'(DATA_W));

  if (DATA_W <= 32) begin : g_trunc
    logic w_unused_def;
    assign w_unused_def = ^w_def;
    assign init_data    = w_def[DATA_W-1:0];
  end else begin : g_zext
    assign init_data = {{(DATA_W-32){1'b0}}, w_def};
  end

endmodule
`default_nettype wire

// File: rtl/prog_target_lut.sv
`default_nettype none
// ============================================================================
// Module   : prog_target_lut
// Purpose  : Run-time writable branch/jump target table, 1-cycle read latency,
//            write-first bypass. Optional even parity via LUT_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module prog_target_lut
  import prog_lut_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  prog_target_lut_if.slave bus
);

`ifdef LUT_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);

  logic              w_init_busy, w_init_we;
  logic [ADDR_W-1:0] w_init_addr;
  logic [DATA_W-1:0] w_init_data;

  logic [MEM_W-1:0]  r_mem [DEPTH];
  logic [MEM_W-1:0]  w_rd_word;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_wr_ready, w_wr_fire, w_rd_fire;
  logic              w_wr_inr, w_rd_inr, w_bypass;

  logic              r_rd_valid, r_addr_err;
  logic [DATA_W-1:0] r_rd_target;

  prog_lut_init_seq #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (w_init_busy),
    .init_we   (w_init_we),
    .init_addr (w_init_addr),
    .init_data (w_init_data)
  );

  function automatic logic [MEM_W-1:0] pack_word(input logic [DATA_W-1:0] d);
`ifdef LUT_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  // Requests are only honoured in RUN and never while reset is asserted.
  assign w_wr_ready = ~w_init_busy;
  assign w_wr_fire  = rst_n & bus.wr_valid & w_wr_ready;
  assign w_rd_fire  = rst_n & bus.rd_en & ~w_init_busy;
  assign w_wr_inr   = {1'b0, bus.wr_addr} < C_DEPTH;
  assign w_rd_inr   = {1'b0, bus.rd_addr} < C_DEPTH;
  assign w_bypass   = w_wr_fire & w_wr_inr & (bus.wr_addr == bus.rd_addr);
  assign w_rd_word  = r_mem[bus.rd_addr];

  always_ff @(posedge clk) begin
    if (rst_n && w_init_we) begin
      r_mem[w_init_addr] <= pack_word(w_init_data);
    end else if (w_wr_fire && w_wr_inr) begin
      r_mem[bus.wr_addr] <= pack_word(bus.wr_data);
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_rd_inr) begin
      w_rd_data = w_bypass ? bus.wr_data : w_rd_word[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid  <= 1'b0;
      r_rd_target <= '0;
      r_addr_err  <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_fire;
      r_addr_err <= (w_rd_fire & ~w_rd_inr) | (w_wr_fire & ~w_wr_inr);
      if (w_rd_fire) begin
        r_rd_target <= w_rd_data;
      end
    end
  end

`ifdef LUT_PARITY_EN
  logic r_par_err;

  // Bypassed data is fresh, so only stored words are checked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par_err <= 1'b0;
    end else begin
      r_par_err <= w_rd_fire & w_rd_inr & ~w_bypass & (^w_rd_word);
    end
  end

  assign bus.par_err = r_par_err;
`endif

  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_target = r_rd_target;
  assign bus.wr_ready  = w_wr_ready;
  assign bus.init_busy = w_init_busy;
  assign bus.addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_target_lut.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_target_lut
// Purpose  : Self-checking bench for prog_target_lut (DEPTH=8 and DEPTH=6).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_target_lut;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prog_target_lut_if #(.DATA_W(8), .ADDR_W(3)) bus8 ();
  prog_target_lut_if #(.DATA_W(8), .ADDR_W(3)) bus6 ();

  prog_target_lut #(.DATA_W(8), .ADDR_W(3), .DEPTH(8)) dut8 (
    .clk (clk), .rst_n (rst_n), .bus (bus8)
  );
  prog_target_lut #(.DATA_W(8), .ADDR_W(3), .DEPTH(6)) dut6 (
    .clk (clk), .rst_n (rst_n), .bus (bus6)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int defs [8] = '{'h8E, 'h6D, 'h5B, 'h05, 'h17, 'h01, 'h00, 'h00};
  int m8 [8];
  int m6 [6];
  int last8, last6;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus8.rd_en = 1'b0; bus8.wr_valid = 1'b0;
    bus6.rd_en = 1'b0; bus6.wr_valid = 1'b0;
  endtask

  task automatic reload_models();
    for (int i = 0; i < 8; i++) m8[i] = defs[i];
    for (int i = 0; i < 6; i++) m6[i] = defs[i];
    last8 = 0;
    last6 = 0;
  endtask

  task automatic rd8(input int a, input string tag);
    bus8.rd_en = 1'b1; bus8.rd_addr = 3'(a);
    step();
    bus8.rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(bus8.rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus8.rd_target), 32'(m8[a]));
    chk({tag, "_aerr"}, 32'(bus8.addr_err), 32'd0);
`ifdef LUT_PARITY_EN
    chk({tag, "_perr"}, 32'(bus8.par_err), 32'd0);
`endif
    last8 = m8[a];
  endtask

  task automatic rd6(input int a, input string tag);
    int exp;
    exp = (a < 6) ? m6[a] : 0;
    bus6.rd_en = 1'b1; bus6.rd_addr = 3'(a);
    step();
    bus6.rd_en = 1'b0;
    chk({tag, "_valid"}, 32'(bus6.rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus6.rd_target), 32'(exp));
    chk({tag, "_aerr"}, 32'(bus6.addr_err), (a >= 6) ? 32'd1 : 32'd0);
    last6 = exp;
  endtask

  task automatic wr8(input int a, input int d, input string tag);
    bus8.wr_valid = 1'b1; bus8.wr_addr = 3'(a); bus8.wr_data = 8'(d);
    chk({tag, "_ready"}, 32'(bus8.wr_ready), 32'd1);
    step();
    bus8.wr_valid = 1'b0;
    chk({tag, "_aerr"}, 32'(bus8.addr_err), 32'd0);
    m8[a] = d;
  endtask

  task automatic wr6(input int a, input int d, input string tag);
    bus6.wr_valid = 1'b1; bus6.wr_addr = 3'(a); bus6.wr_data = 8'(d);
    chk({tag, "_ready"}, 32'(bus6.wr_ready), 32'd1);
    step();
    bus6.wr_valid = 1'b0;
    chk({tag, "_aerr"}, 32'(bus6.addr_err), (a >= 6) ? 32'd1 : 32'd0);
    if (a < 6) m6[a] = d;
  endtask

  // Counts INIT cycles while hammering both request ports on the DEPTH=8 table.
  task automatic count_init(input string tag);
    int cnt;
    cnt = 0;
    bus8.rd_en = 1'b1; bus8.rd_addr = 3'd1;
    bus8.wr_valid = 1'b1; bus8.wr_addr = 3'd0; bus8.wr_data = 8'hFF;
    while (bus8.init_busy === 1'b1 && cnt < 50) begin
      chk({tag, "_wready"}, 32'(bus8.wr_ready), 32'd0);
      cnt++;
      step();
      chk({tag, "_rdrop"}, 32'(bus8.rd_valid), 32'd0);
      chk({tag, "_aerr"}, 32'(bus8.addr_err), 32'd0);
    end
    idle_all();
    chk({tag, "_cycles"}, 32'(cnt), 32'd8);
  endtask

  initial begin
    int re, we, ra, wa, wd, e8, e6, err6;
    idle_all();
    bus8.rd_addr = '0; bus8.wr_addr = '0; bus8.wr_data = '0;
    bus6.rd_addr = '0; bus6.wr_addr = '0; bus6.wr_data = '0;

    // Reset state
    rst_n = 1'b0;
    step();
    step();
    chk("rst_rd_valid", 32'(bus8.rd_valid), 32'd0);
    chk("rst_rd_target", 32'(bus8.rd_target), 32'd0);
    chk("rst_wr_ready", 32'(bus8.wr_ready), 32'd0);
    chk("rst_addr_err", 32'(bus8.addr_err), 32'd0);
    chk("rst_init_busy", 32'(bus8.init_busy), 32'd1);
    chk("rst6_init_busy", 32'(bus6.init_busy), 32'd1);

    // Default load and dropped INIT-phase requests
    rst_n = 1'b1;
    count_init("init1");
    reload_models();
    chk("run_wr_ready", 32'(bus8.wr_ready), 32'd1);
    chk("run6_busy", 32'(bus6.init_busy), 32'd0);
    for (int i = 0; i < 8; i++) rd8(i, $sformatf("dflt%0d", i));
    step();
    chk("rd_valid_pulse", 32'(bus8.rd_valid), 32'd0);
    chk("rd_target_hold", 32'(bus8.rd_target), 32'(last8));

    // Run-time write then read back, others intact
    wr8(3, 'hA5, "wr3");
    for (int i = 0; i < 8; i++) rd8(i, $sformatf("post_wr%0d", i));

    // Same-cycle write/read on one index returns the new data
    bus8.wr_valid = 1'b1; bus8.wr_addr = 3'd2; bus8.wr_data = 8'h3C;
    bus8.rd_en = 1'b1; bus8.rd_addr = 3'd2;
    step();
    idle_all();
    chk("bypass_valid", 32'(bus8.rd_valid), 32'd1);
    chk("bypass_data", 32'(bus8.rd_target), 32'h3C);
    m8[2] = 'h3C;
    last8 = 'h3C;
    rd8(2, "bypass_stored");

    // Out-of-range on DEPTH=6
    for (int i = 0; i < 6; i++) rd6(i, $sformatf("d6_dflt%0d", i));
    rd6(7, "oor_rd7");
    step();
    chk("oor_pulse", 32'(bus6.addr_err), 32'd0);
    wr6(6, 'h77, "oor_wr6");
    for (int i = 0; i < 6; i++) rd6(i, $sformatf("d6_keep%0d", i));
    bus6.rd_en = 1'b1; bus6.rd_addr = 3'd7;
    bus6.wr_valid = 1'b1; bus6.wr_addr = 3'd6; bus6.wr_data = 8'h55;
    step();
    idle_all();
    chk("oor_both_err", 32'(bus6.addr_err), 32'd1);
    chk("oor_both_data", 32'(bus6.rd_target), 32'd0);
    step();
    chk("oor_both_single", 32'(bus6.addr_err), 32'd0);
    last6 = 0;

    // Randomized traffic against the array model, both depths in parallel
    for (int k = 0; k < 120; k++) begin
      re = int'($urandom_range(0, 1));
      we = int'($urandom_range(0, 1));
      ra = int'($urandom_range(0, 7));
      wa = int'($urandom_range(0, 7));
      wd = int'($urandom_range(0, 255));
      bus8.rd_en = re[0]; bus8.rd_addr = 3'(ra);
      bus8.wr_valid = we[0]; bus8.wr_addr = 3'(wa); bus8.wr_data = 8'(wd);
      bus6.rd_en = re[0]; bus6.rd_addr = 3'(ra);
      bus6.wr_valid = we[0]; bus6.wr_addr = 3'(wa); bus6.wr_data = 8'(wd);
      step();
      idle_all();
      if (re != 0) e8 = (we != 0 && wa == ra) ? wd : m8[ra];
      else         e8 = last8;
      if (re == 0)         e6 = last6;
      else if (ra >= 6)    e6 = 0;
      else if (we != 0 && wa == ra) e6 = wd;
      else                 e6 = m6[ra];
      err6 = ((re != 0 && ra >= 6) || (we != 0 && wa >= 6)) ? 1 : 0;
      chk("rnd8_valid", 32'(bus8.rd_valid), 32'(re));
      chk("rnd8_data", 32'(bus8.rd_target), 32'(e8));
      chk("rnd8_aerr", 32'(bus8.addr_err), 32'd0);
      chk("rnd6_valid", 32'(bus6.rd_valid), 32'(re));
      chk("rnd6_data", 32'(bus6.rd_target), 32'(e6));
      chk("rnd6_aerr", 32'(bus6.addr_err), 32'(err6));
      if (we != 0) m8[wa] = wd;
      if (we != 0 && wa < 6) m6[wa] = wd;
      last8 = e8;
      last6 = e6;
    end

    // Reset in the middle of INIT restarts the full load
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("midinit_busy", 32'(bus8.init_busy), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midinit_rst_target", 32'(bus8.rd_target), 32'd0);
    count_init("init2");
    reload_models();
    for (int i = 0; i < 8; i++) rd8(i, $sformatf("reload%0d", i));
    for (int i = 0; i < 6; i++) rd6(i, $sformatf("d6_reload%0d", i));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
